// File: rtl/icache_axi_refill_master.sv
// AXI4 read-burst master that fetches one cache line per refill request,
// with INCR (line-aligned) or WRAP (critical-word-first) bursts and per-line error reporting.
module icache_axi_refill_master #(
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int WRAP_EN    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       refill_addr,
  input  logic              refill_start,
  output logic              refill_busy,
  output logic              refill_done,
  output logic              refill_err,
  output logic [DATA_W-1:0] refill_data,
  output logic [$clog2(LINE_WORDS)-1:0] refill_word,
  output logic              refill_data_valid,
  output logic              refill_crit,
  output logic [31:0]       M_AXI_ARADDR,
  output logic [7:0]        M_AXI_ARLEN,
  output logic [2:0]        M_AXI_ARSIZE,
  output logic [1:0]        M_AXI_ARBURST,
  output logic [2:0]        M_AXI_ARPROT,
  output logic              M_AXI_ARVALID,
  input  logic              M_AXI_ARREADY,
  input  logic [DATA_W-1:0] M_AXI_RDATA,
  input  logic [1:0]        M_AXI_RRESP,
  input  logic              M_AXI_RLAST,
  input  logic              M_AXI_RVALID,
  output logic              M_AXI_RREADY
);

  localparam int OFF  = $clog2(DATA_W / 8);
  localparam int WIDX = $clog2(LINE_WORDS);
  localparam logic [31:0] ADDR_MASK = (WRAP_EN != 0) ? ~((32'd1 << OFF) - 32'd1)
                                                     : ~((32'd1 << (OFF + WIDX)) - 32'd1);
  localparam logic [WIDX:0]   LAST_BEAT = (WIDX + 1)'(LINE_WORDS - 1);
  localparam logic [WIDX:0]   CNT_ONE   = (WIDX + 1)'(1);
  localparam logic [WIDX-1:0] WORD_ONE  = WIDX'(1);

  typedef enum logic [1:0] {IDLE, AR, R} state_t;

  state_t          state, state_next;
  logic [WIDX:0]   beat_cnt;
  logic [WIDX-1:0] word_idx;
  logic [WIDX-1:0] start_idx;
  logic            err_acc;
  logic            beat, last_count, finish, err_next;

  assign M_AXI_ARLEN   = 8'(LINE_WORDS - 1);
  assign M_AXI_ARSIZE  = 3'(OFF);
  assign M_AXI_ARBURST = (WRAP_EN != 0) ? 2'b10 : 2'b01;
  assign M_AXI_ARPROT  = 3'b100;

  assign start_idx  = (WRAP_EN != 0) ? refill_addr[OFF+WIDX-1:OFF] : '0;
  assign beat       = M_AXI_RVALID && M_AXI_RREADY;
  assign last_count = (beat_cnt == LAST_BEAT);
  assign finish     = beat && (M_AXI_RLAST || last_count);
  // A beat is bad if the slave flags SLVERR/DECERR or RLAST disagrees with our own beat count.
  assign err_next   = err_acc | (M_AXI_RRESP >= 2'b10) | (M_AXI_RLAST != last_count);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (refill_start)  state_next = AR;
      AR:      if (M_AXI_ARREADY) state_next = R;
      R:       if (finish)        state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      refill_busy       <= 1'b0;
      refill_done       <= 1'b0;
      refill_err        <= 1'b0;
      refill_data       <= '0;
      refill_word       <= '0;
      refill_data_valid <= 1'b0;
      refill_crit       <= 1'b0;
      M_AXI_ARADDR      <= '0;
      M_AXI_ARVALID     <= 1'b0;
      M_AXI_RREADY      <= 1'b0;
      beat_cnt          <= '0;
      word_idx          <= '0;
      err_acc           <= 1'b0;
    end else begin
      refill_data_valid <= 1'b0;
      refill_crit       <= 1'b0;
      refill_done       <= 1'b0;
      case (state)
        IDLE: begin
          if (refill_start) begin
            M_AXI_ARADDR  <= refill_addr & ADDR_MASK;
            M_AXI_ARVALID <= 1'b1;
            refill_busy   <= 1'b1;
            beat_cnt      <= '0;
            err_acc       <= 1'b0;
            word_idx      <= start_idx;
          end
        end
        AR: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
          end
        end
        R: begin
          if (beat) begin
            refill_data       <= M_AXI_RDATA;
            refill_word       <= word_idx;
            refill_data_valid <= 1'b1;
            refill_crit       <= (beat_cnt == '0);
            word_idx          <= word_idx + WORD_ONE;
            beat_cnt          <= beat_cnt + CNT_ONE;
            err_acc           <= err_next;
            // Line ends on early RLAST or on the last counted beat, whichever comes first.
            if (finish) begin
              M_AXI_RREADY <= 1'b0;
              refill_busy  <= 1'b0;
              refill_done  <= 1'b1;
              refill_err   <= err_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
